// File: rtl/wb_unified_mem_arbiter_pkg.sv
// Shared encodings for the iwb/dwb unified-memory Wishbone arbiter:
// FSM states, grant codes and the default dwb run limit.
package wb_unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_GNT_I = 2'b01,
    ARB_GNT_D = 2'b10
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_I    = 2'b01,
    GNT_D    = 2'b10
  } gnt_code_t;

  localparam int DEF_MAX_D_RUN = 4;
  localparam int RUN_W         = 4;

endpackage

// File: rtl/wb_arb_priority.sv
// Next-grant decision: dwb has fixed priority, except that iwb wins once
// dwb has taken MAX_D_RUN consecutive grants while iwb was waiting.
module wb_arb_priority
  import wb_unified_mem_arbiter_pkg::*;
#(
  parameter int MAX_D_RUN = DEF_MAX_D_RUN
) (
  input  logic             i_req,
  input  logic             d_req,
  input  logic [RUN_W-1:0] run_cnt,
  output gnt_code_t        gnt
);

  localparam logic [RUN_W-1:0] MAX_RUN_C = RUN_W'(MAX_D_RUN);

  // Pick the master that would be granted out of IDLE this cycle.
  always_comb begin
    gnt = GNT_NONE;
    if (d_req && i_req) begin
      if (run_cnt == MAX_RUN_C) begin
        gnt = GNT_I;
      end else begin
        gnt = GNT_D;
      end
    end else if (d_req) begin
      gnt = GNT_D;
    end else if (i_req) begin
      gnt = GNT_I;
    end else begin
      gnt = GNT_NONE;
    end
  end

endmodule

// File: rtl/wb_unified_mem_arbiter.sv
// Two-master (iwb read-only, dwb read/write) to one-slave Wishbone classic arbiter.
// Optional grant watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_unified_mem_arbiter
  import wb_unified_mem_arbiter_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_D_RUN = DEF_MAX_D_RUN
`ifdef WB_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   i_adr_i,
  input  logic            i_cyc_i,
  input  logic            i_stb_i,
  output logic [DW-1:0]   i_dat_o,
  output logic            i_ack_o,
  output logic            i_err_o,
  input  logic [AW-1:0]   d_adr_i,
  input  logic [DW-1:0]   d_dat_i,
  input  logic            d_we_i,
  input  logic [DW/8-1:0] d_sel_i,
  input  logic            d_cyc_i,
  input  logic            d_stb_i,
  output logic [DW-1:0]   d_dat_o,
  output logic            d_ack_o,
  output logic            d_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      gnt_o
);

  localparam int SW = DW / 8;
  localparam logic [RUN_W-1:0] MAX_RUN_C = RUN_W'(MAX_D_RUN);

  arb_state_t       state_r;
  arb_state_t       state_nxt_s;
  logic [RUN_W-1:0] run_r;
  logic [RUN_W-1:0] run_nxt_s;
  gnt_code_t        pick_s;
  logic             i_req_s;
  logic             d_req_s;
  logic             tmo_s;

  assign i_req_s = i_cyc_i & i_stb_i;
  assign d_req_s = d_cyc_i & d_stb_i;

  wb_arb_priority #(
    .MAX_D_RUN (MAX_D_RUN)
  ) u_priority (
    .i_req   (i_req_s),
    .d_req   (d_req_s),
    .run_cnt (run_r),
    .gnt     (pick_s)
  );

`ifdef WB_ARB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;
  logic [WD_W-1:0] wd_r;

  // Grant watchdog: zero in IDLE so it restarts on every grant entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_r <= {WD_W{1'b0}};
    end else if (state_r == ARB_IDLE) begin
      wd_r <= {WD_W{1'b0}};
    end else begin
      wd_r <= wd_r + WD_W'(1);
    end
  end

  // Kept free of s_ack_i so a combinational slave cannot form a loop via s_cyc_o.
  assign tmo_s = (state_r != ARB_IDLE) && (wd_r == WD_W'(TIMEOUT_CYCLES));
`else
  assign tmo_s = 1'b0;
`endif

  // State and dwb run-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ARB_IDLE;
      run_r   <= {RUN_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      run_r   <= run_nxt_s;
    end
  end

  // Next state; the run counter only moves when a grant is taken from IDLE.
  always_comb begin
    state_nxt_s = state_r;
    run_nxt_s   = run_r;
    case (state_r)
      ARB_IDLE: begin
        case (pick_s)
          GNT_I: begin
            state_nxt_s = ARB_GNT_I;
            run_nxt_s   = {RUN_W{1'b0}};
          end
          GNT_D: begin
            state_nxt_s = ARB_GNT_D;
            if (!i_req_s) begin
              run_nxt_s = {RUN_W{1'b0}};
            end else if (run_r == MAX_RUN_C) begin
              run_nxt_s = run_r;
            end else begin
              run_nxt_s = run_r + RUN_W'(1);
            end
          end
          default: begin
            state_nxt_s = ARB_IDLE;
          end
        endcase
      end
      ARB_GNT_I: begin
        if (s_ack_i || s_err_i || !i_cyc_i || tmo_s) begin
          state_nxt_s = ARB_IDLE;
        end else begin
          state_nxt_s = ARB_GNT_I;
        end
      end
      ARB_GNT_D: begin
        if (s_ack_i || s_err_i || !d_cyc_i || tmo_s) begin
          state_nxt_s = ARB_IDLE;
        end else begin
          state_nxt_s = ARB_GNT_D;
        end
      end
      default: begin
        state_nxt_s = ARB_IDLE;
      end
    endcase
  end

  // Slave-side mux and response routing to the granted master only.
  always_comb begin
    s_adr_o = {AW{1'b0}};
    s_dat_o = {DW{1'b0}};
    s_we_o  = 1'b0;
    s_sel_o = {SW{1'b0}};
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    i_ack_o = 1'b0;
    i_err_o = 1'b0;
    d_ack_o = 1'b0;
    d_err_o = 1'b0;
    gnt_o   = GNT_NONE;
    case (state_r)
      ARB_GNT_I: begin
        s_adr_o = i_adr_i;
        s_sel_o = {SW{1'b1}};
        s_cyc_o = i_cyc_i & ~tmo_s;
        s_stb_o = i_stb_i & ~tmo_s;
        i_ack_o = s_ack_i;
        i_err_o = s_err_i | (tmo_s & ~s_ack_i);
        gnt_o   = GNT_I;
      end
      ARB_GNT_D: begin
        s_adr_o = d_adr_i;
        s_dat_o = d_dat_i;
        s_we_o  = d_we_i;
        s_sel_o = d_sel_i;
        s_cyc_o = d_cyc_i & ~tmo_s;
        s_stb_o = d_stb_i & ~tmo_s;
        d_ack_o = s_ack_i;
        d_err_o = s_err_i | (tmo_s & ~s_ack_i);
        gnt_o   = GNT_D;
      end
      default: begin
        gnt_o = GNT_NONE;
      end
    endcase
  end

  assign i_dat_o = s_dat_i;
  assign d_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_unified_mem_arbiter.sv
// Directed bench for wb_unified_mem_arbiter with a registered 1-cycle-ack slave model.
// Define WB_ARB_TIMEOUT_EN to also exercise the grant watchdog.
module tb_wb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_adr_i;
  logic        i_cyc_i, i_stb_i;
  logic [31:0] i_dat_o;
  logic        i_ack_o, i_err_o;
  logic [31:0] d_adr_i, d_dat_i;
  logic        d_we_i;
  logic [3:0]  d_sel_i;
  logic        d_cyc_i, d_stb_i;
  logic [31:0] d_dat_o;
  logic        d_ack_o, d_err_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic        s_we_o;
  logic [3:0]  s_sel_o;
  logic        s_cyc_o, s_stb_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_err_i;
  logic [1:0]  gnt_o;

  logic        slv_en, slv_err, resp_r;
  logic [31:0] rdata;

  typedef struct {
    logic [1:0]  code;
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } xfer_t;

  xfer_t       log_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          i_acks, d_acks, i_errs, d_errs;
  int          first_i_ack, last_i_ack;
  logic [31:0] last_i_dat, last_d_dat;

  always #5 clk = ~clk;

`ifdef WB_ARB_TIMEOUT_EN
  wb_unified_mem_arbiter #(.AW(32), .DW(32), .MAX_D_RUN(4), .TIMEOUT_CYCLES(8)) dut (
`else
  wb_unified_mem_arbiter #(.AW(32), .DW(32), .MAX_D_RUN(4)) dut (
`endif
    .clk(clk), .rst_n(rst_n),
    .i_adr_i(i_adr_i), .i_cyc_i(i_cyc_i), .i_stb_i(i_stb_i),
    .i_dat_o(i_dat_o), .i_ack_o(i_ack_o), .i_err_o(i_err_o),
    .d_adr_i(d_adr_i), .d_dat_i(d_dat_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i),
    .d_cyc_i(d_cyc_i), .d_stb_i(d_stb_i),
    .d_dat_o(d_dat_o), .d_ack_o(d_ack_o), .d_err_o(d_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .gnt_o(gnt_o)
  );

  // Slave model: responds one cycle after seeing cyc&stb, single beat.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) resp_r <= 1'b0;
    else        resp_r <= s_cyc_o & s_stb_o & ~resp_r & slv_en;
  end
  assign s_ack_i = resp_r & ~slv_err;
  assign s_err_i = resp_r & slv_err;
  assign s_dat_i = rdata;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] code_at(input int k);
    if (k < log_q.size()) return log_q[k].code;
    return 2'b11;
  endfunction

  // Issue n_i iwb and n_d dwb transfers; log every grant start and every response.
  task automatic run_traffic(input int n_i, input int n_d, input int budget);
    int         i_left, d_left;
    logic [1:0] prev_gnt;
    log_q.delete();
    i_acks = 0; d_acks = 0; i_errs = 0; d_errs = 0;
    first_i_ack = -1; last_i_ack = -1;
    i_left = n_i; d_left = n_d;
    prev_gnt = 2'b00;
    i_cyc_i = (n_i > 0); i_stb_i = (n_i > 0);
    d_cyc_i = (n_d > 0); d_stb_i = (n_d > 0);
    for (int c = 0; c < budget && (i_cyc_i || d_cyc_i); c++) begin
      @(negedge clk);
      if (gnt_o != 2'b00 && prev_gnt == 2'b00)
        log_q.push_back('{code: gnt_o, adr: s_adr_o, we: s_we_o, sel: s_sel_o, dat: s_dat_o});
      prev_gnt = gnt_o;
      if (i_ack_o || i_err_o) begin
        if (i_ack_o) begin
          i_acks++; last_i_dat = i_dat_o;
          if (first_i_ack < 0) first_i_ack = c;
          last_i_ack = c;
        end else begin
          i_errs++;
        end
        i_left--;
        if (i_left <= 0) begin i_cyc_i = 1'b0; i_stb_i = 1'b0; end
      end
      if (d_ack_o || d_err_o) begin
        if (d_ack_o) begin d_acks++; last_d_dat = d_dat_o; end
        else d_errs++;
        d_left--;
        if (d_left <= 0) begin d_cyc_i = 1'b0; d_stb_i = 1'b0; end
      end
    end
    check_val("traffic_done", {i_cyc_i, d_cyc_i}, 2'b00);
    i_cyc_i = 1'b0; i_stb_i = 1'b0; d_cyc_i = 1'b0; d_stb_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    string exp_ord;
    int    err_at, err_cnt;
    rst_n = 1'b0;
    i_adr_i = 32'h0; i_cyc_i = 1'b0; i_stb_i = 1'b0;
    d_adr_i = 32'h0; d_dat_i = 32'h0; d_we_i = 1'b0; d_sel_i = 4'h0;
    d_cyc_i = 1'b0; d_stb_i = 1'b0;
    slv_en = 1'b1; slv_err = 1'b0; rdata = 32'h0;
    repeat (2) @(negedge clk);
    check_val("rst_gnt", gnt_o, 2'b00);
    check_val("rst_ctl", {s_cyc_o, s_stb_o, s_we_o, i_ack_o, i_err_o, d_ack_o, d_err_o}, 7'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // iwb read alone
    i_adr_i = 32'h100; rdata = 32'h0000_0013;
    run_traffic(1, 0, 20);
    check_val("t1_ngrant", log_q.size(), 1);
    check_val("t1_code", code_at(0), 2'b01);
    if (log_q.size() > 0) begin
      check_val("t1_adr", log_q[0].adr, 32'h100);
      check_val("t1_we_sel_dat", {log_q[0].we, log_q[0].sel, log_q[0].dat}, {1'b0, 4'hF, 32'h0});
    end
    check_val("t1_iack", i_acks, 1);
    check_val("t1_idat", last_i_dat, 32'h0000_0013);
    check_val("t1_dack", d_acks, 0);
    check_val("t1_ack_lat", first_i_ack, 1);

    // two back-to-back iwb reads: 3 cycles per access
    @(negedge clk);
    i_adr_i = 32'h104; rdata = 32'h0000_0093;
    run_traffic(2, 0, 20);
    check_val("tput_acks", i_acks, 2);
    check_val("tput_period", last_i_ack - first_i_ack, 3);

    // simultaneous iwb read and dwb write: dwb first
    @(negedge clk);
    i_adr_i = 32'h108; rdata = 32'h1234_5678;
    d_adr_i = 32'h1000; d_dat_i = 32'hDEAD_BEEF; d_we_i = 1'b1; d_sel_i = 4'b0011;
    run_traffic(1, 1, 30);
    check_val("t2_order", {code_at(0), code_at(1)}, {2'b10, 2'b01});
    if (log_q.size() > 0) begin
      check_val("t2_d_adr", log_q[0].adr, 32'h1000);
      check_val("t2_d_we_sel", {log_q[0].we, log_q[0].sel}, {1'b1, 4'b0011});
      check_val("t2_d_wdat", log_q[0].dat, 32'hDEAD_BEEF);
    end
    check_val("t2_acks", {i_acks[7:0], d_acks[7:0]}, {8'd1, 8'd1});

    // slave error on a dwb read is completion and goes to dwb only
    @(negedge clk);
    d_we_i = 1'b0; d_sel_i = 4'hF; slv_err = 1'b1;
    run_traffic(0, 1, 20);
    check_val("err_route", {d_errs[7:0], d_acks[7:0], i_errs[7:0]}, {8'd1, 8'd0, 8'd0});
    slv_err = 1'b0;

    // dwb run limit: 10 dwb transfers, iwb pending
    @(negedge clk);
    rdata = 32'hCAFE_0001;
    run_traffic(2, 10, 200);
    exp_ord = "DDDDIDDDDIDD";
    check_val("t3_ngrant", log_q.size(), 12);
    for (int k = 0; k < 12; k++)
      check_val($sformatf("t3_grant%0d", k), code_at(k), (exp_ord[k] == 8'h44) ? 2'b10 : 2'b01);
    check_val("t3_acks", {i_acks[7:0], d_acks[7:0]}, {8'd2, 8'd10});

    // dwb aborts one cycle into its grant
    @(negedge clk);
    @(negedge clk);
    rdata = 32'h0BAD_F00D;
    i_cyc_i = 1'b1; i_stb_i = 1'b1; d_cyc_i = 1'b1; d_stb_i = 1'b1;
    @(negedge clk);
    check_val("t4_gnt_d", gnt_o, 2'b10);
    d_cyc_i = 1'b0; d_stb_i = 1'b0;
    @(negedge clk);
    check_val("t4_idle", {gnt_o, i_ack_o, d_ack_o, i_err_o, d_err_o}, 6'b00_0000);
    @(negedge clk);
    check_val("t4_gnt_i", {gnt_o, d_ack_o, s_cyc_o}, {2'b01, 1'b0, 1'b1});
    @(negedge clk);
    check_val("t4_iack", {i_ack_o, d_ack_o}, 2'b10);
    i_cyc_i = 1'b0; i_stb_i = 1'b0;
    @(negedge clk);

    // async reset while dwb waits for an ack that never comes
    slv_en = 1'b0;
    d_cyc_i = 1'b1; d_stb_i = 1'b1;
    @(negedge clk);
    check_val("t5_gnt_d", gnt_o, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    check_val("t5_async", {gnt_o, s_cyc_o, s_stb_o, d_ack_o}, 5'b0);
    d_cyc_i = 1'b0; d_stb_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; slv_en = 1'b1;
    @(negedge clk);
    i_adr_i = 32'h200; rdata = 32'hA5A5_0001;
    run_traffic(1, 0, 20);
    check_val("t5_regrant", code_at(0), 2'b01);
    check_val("t5_iack", {i_acks[7:0], last_i_dat}, {8'd1, 32'hA5A5_0001});

`ifdef WB_ARB_TIMEOUT_EN
    // watchdog: slave never answers an iwb read
    @(negedge clk);
    slv_en = 1'b0; i_adr_i = 32'h300;
    i_cyc_i = 1'b1; i_stb_i = 1'b1;
    err_at = -1; err_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (err_at >= 0 && c == err_at + 1) check_val("t6_idle", gnt_o, 2'b00);
      if (i_err_o) begin
        err_cnt++;
        if (err_at < 0) begin
          err_at = c;
          check_val("t6_cyc_low", {s_cyc_o, i_ack_o}, 2'b00);
          i_cyc_i = 1'b0; i_stb_i = 1'b0;
        end
      end
    end
    i_cyc_i = 1'b0; i_stb_i = 1'b0;
    check_val("t6_err_cycle", err_at, 8);
    check_val("t6_err_pulses", err_cnt, 1);
    slv_en = 1'b1; rdata = 32'h7777_0000; d_adr_i = 32'h2000;
    run_traffic(0, 1, 20);
    check_val("t6_next_d", {code_at(0), d_acks[7:0], last_d_dat}, {2'b10, 8'd1, 32'h7777_0000});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_unified_mem_arbiter.md
Name: wb_unified_mem_arbiter

Overview:
Two-master to one-slave Wishbone classic arbiter.
- Lets the core's instruction port (iwb, read-only) and data port (dwb, read/write) share one single-ported unified memory.
- Unified code and data storage supports self-modifying code and FENCE.I.
- Sits between the core's iwb/dwb buses and the memory or tohost slave.
- Guarantees one transfer at a time, fixed data priority, and bounded instruction starvation.

Parameters:
AW, 32, address width
DW, 32, data width (byte lanes = DW/8)
MAX_D_RUN, 4, max consecutive dwb grants while iwb is pending; 1..15
TIMEOUT_CYCLES, 255, watchdog limit; used only with WB_ARB_TIMEOUT_EN

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_adr_i  in  AW  iwb address
i_cyc_i, i_stb_i  in  1  iwb cycle / strobe
i_dat_o  out  DW  iwb read data
i_ack_o, i_err_o  out  1  iwb acknowledge / error
d_adr_i  in  AW  dwb address
d_dat_i  in  DW  dwb write data
d_we_i  in  1  dwb write enable
d_sel_i  in  DW/8  dwb byte select
d_cyc_i, d_stb_i  in  1  dwb cycle / strobe
d_dat_o  out  DW  dwb read data
d_ack_o, d_err_o  out  1  dwb acknowledge / error
s_adr_o  out  AW  slave address
s_dat_o  out  DW  slave write data
s_we_o  out  1  slave write enable
s_sel_o  out  DW/8  slave byte select
s_cyc_o, s_stb_o  out  1  slave cycle / strobe
s_dat_i  in  DW  slave read data
s_ack_i, s_err_i  in  1  slave acknowledge / error
gnt_o  out  2  grant status: 01 = iwb, 10 = dwb, 00 = none

Behaviour:
Reset:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- FSM goes to IDLE; run counter = 0; gnt_o = 00.
- All s_* control outputs, acks and errs are 0.
- Reset mid-transfer abandons the transfer immediately; no ack is delivered.

FSM states: IDLE, GNT_I, GNT_D.
- IDLE: request is cyc&stb.
  - d only -> GNT_D.
  - i only -> GNT_I.
  - Both -> GNT_D, unless run counter == MAX_D_RUN, then GNT_I.
- GNT_x: slave signals are muxed combinationally from master x.
  - s_cyc_o = x_cyc_i; s_stb_o = x_stb_i.
  - For iwb: s_we_o = 0, s_sel_o = all ones, s_dat_o = 0.
- Exit GNT_x to IDLE on any of:
  - s_ack_i or s_err_i (single-beat transfers);
  - x_cyc_i low (abort, no ack forwarded).
- Arbitration overhead: exactly 1 cycle in IDLE between transfers, so minimum 3 cycles per access with a 1-cycle-ack slave.

Response routing:
- s_ack_i / s_err_i go to the granted master only, combinationally, same cycle.
- The non-granted master sees ack = err = 0.
- i_dat_o and d_dat_o both mirror s_dat_i; they are valid only with ack.

Run counter:
- Increments on each dwb grant taken while iwb is requesting; saturates at MAX_D_RUN.
- Clears on an iwb grant, or when iwb is not requesting at grant time.

Other rules:
- A master asserting stb while not granted waits; its signals must stay stable.
- The arbiter adds no buffering.
- s_err_i is treated as transfer completion.

Optional Feature:
WB_ARB_TIMEOUT_EN:
- Defined:
  - An 8..16-bit watchdog counts cycles in GNT_x and clears on entry.
  - On reaching TIMEOUT_CYCLES with no ack/err, x_err_o pulses high for 1 cycle.
  - s_cyc_o is forced low that cycle; FSM goes to IDLE.
  - A late s_ack_i after the timeout is ignored.
- Undefined: no counter exists; the grant is held indefinitely until ack, err or abort.

Decomposition:
Shared package/defines header (alongside riscv_defines.vh):
- State encodings ARB_IDLE / ARB_GNT_I / ARB_GNT_D.
- Grant codes GNT_NONE / GNT_I / GNT_D.
- Default MAX_D_RUN.

Natural sub-module: wb_arb_priority, the combinational next-grant decision from (i_req, d_req, run_cnt) to grant code. The FSM, muxes and watchdog stay in the top module.

Test Plan:
1. iwb read of 0x100 alone, slave acks 1 cycle after stb with 0x00000013 -> gnt_o = 01; i_ack_o pulses once with i_dat_o = 0x00000013; d_ack_o stays 0.
2. iwb and dwb request in the same cycle (dwb write 0xDEADBEEF to 0x1000, sel = 0011) -> dwb served first with s_sel_o = 0011 and s_we_o = 1; iwb served in the next grant.
3. dwb back-to-back for 10 transfers, iwb pending throughout, MAX_D_RUN = 4 -> iwb granted after the 4th dwb transfer; grant order DDDDIDDDDI...
4. dwb drops cyc 1 cycle into the grant, no ack -> FSM returns to IDLE; pending iwb granted on the following arbitration cycle; no spurious ack to either master.
5. rst_n asserted while GNT_D awaits ack -> s_cyc_o = 0 and gnt_o = 00 immediately (asynchronous); after release, the first iwb request is granted normally.
6. WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, slave never acks an iwb read -> i_err_o high for 1 cycle, 8 cycles after grant; FSM in IDLE; next dwb request is served.
